alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters.
- Round-robin arbitration, valid/ready request handshake, registered response with valid/ready backpressure.
- Sits between instruction-side/test sequencers and the ALU instance; drives the ALU's ALU_Control/operand_A/operand_B from registers and captures ALU_result/zero.
- One transaction in flight at a time.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: operands registered toward the ALU, result registered back.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CTRL_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_control,
  input  logic [WIDTH-1:0]      req0_operand_A,
  input  logic [WIDTH-1:0]      req0_operand_B,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_control,
  input  logic [WIDTH-1:0]      req1_operand_A,
  input  logic [WIDTH-1:0]      req1_operand_B,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic [CTRL_WIDTH-1:0] alu_control,
  output logic [WIDTH-1:0]      alu_operand_A,
  output logic [WIDTH-1:0]      alu_operand_B,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] control;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
  } op_t;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              grant_c;
  logic              accept_c;
  op_t               req0_op_c, req1_op_c;

  assign req0_op_c = {req0_control, req0_operand_A, req0_operand_B};
  assign req1_op_c = {req1_control, req1_operand_A, req1_operand_B};

  // Round-robin pick: on contention the requester not served last time wins.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  // Readies are held low while reset is asserted so nothing looks accepted.
  assign req0_ready = reset && (state_q == IDLE) && req0_valid && !grant_c;
  assign req1_ready = reset && (state_q == IDLE) && req1_valid &&  grant_c;
  assign accept_c   = req0_ready || req1_ready;

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d         = grant_c ? req1_op_c : req0_op_c;
          id_d         = grant_c;
          last_grant_d = grant_c;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_control   = op_q.control;
  assign alu_operand_A = op_q.a;
  assign alu_operand_B = op_q.b;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model, with a behavioural ALU closing the loop.
module tb_alu_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_control;
  logic [31:0] req0_operand_A, req0_operand_B;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_control;
  logic [31:0] req1_operand_A, req1_operand_B;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_operand_A, alu_operand_B, alu_result;
  logic        alu_zero;
  logic        busy;

  int   tests_run;
  int   tests_failed;
  logic model_last;

  alu_arbiter #(.WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_operand_A(req0_operand_A), .req0_operand_B(req0_operand_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_operand_A(req1_operand_A), .req1_operand_B(req1_operand_B),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_control(alu_control), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Behavioural MIPS-style ALU.
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_f = ~(a | b);
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_control, alu_operand_A, alu_operand_B);
  assign alu_zero   = (alu_result == 32'd0);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      tests_run++;
      if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_ctrl: got rdy0/rdy1/rsp_valid/busy=%b expected 0000", {req0_ready, req1_ready, rsp_valid, busy});
      end
      tests_run++;
      if ({alu_control, alu_operand_A, alu_operand_B, rsp_result} !== 100'd0) begin
        tests_failed++;
        $display("FAIL reset_data: got ctrl=%h A=%h B=%h res=%h expected all 0", alu_control, alu_operand_A, alu_operand_B, rsp_result);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got rdy1/rdy0=%b expected 01", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    req0_control = 4'b0010; req0_operand_A = 32'd5; req0_operand_B = 32'd7;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_ready: got rdy1/rdy0=%b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clock);
    req0_valid = 1'b0;
    tests_run++;
    if ({busy, rsp_valid, req0_ready, alu_control, alu_operand_A, alu_operand_B} !== {3'b100, 4'b0010, 32'd5, 32'd7}) begin
      tests_failed++;
      $display("FAIL single_exec: got busy=%b rsp_valid=%b rdy0=%b ctrl=%h A=%h B=%h expected 1 0 0 2 5 7",
               busy, rsp_valid, req0_ready, alu_control, alu_operand_A, alu_operand_B);
    end
    @(negedge clock);
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {3'b100, 32'd12}) begin
      tests_failed++;
      $display("FAIL single_rsp: got valid=%b id=%b zero=%b res=%0d expected 1 0 0 12", rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    @(negedge clock);
    tests_run++;
    if ({rsp_valid, busy, rsp_result} !== {2'b00, 32'd12}) begin
      tests_failed++;
      $display("FAIL single_done: got valid=%b busy=%b res=%0d expected 0 0 12", rsp_valid, busy, rsp_result);
    end
    model_last = 1'b0;
  endtask

  task automatic test_contention();
    int   last_n;
    int   n;
    logic exp_id;
    req0_control = 4'b0110; req0_operand_A = 32'd10; req0_operand_B = 32'd4;
    req1_control = 4'b0111; req1_operand_A = 32'd2;  req1_operand_B = 32'd4;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n = 0; last_n = 0;
    for (int k = 0; k < 6; k++) begin
      int waited = 0;
      while (!(req0_ready || req1_ready) && waited < 8) begin
        @(negedge clock); n++; waited++;
      end
      exp_id = ~model_last;
      tests_run++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got rdy1/rdy0=%b expected id %0d", k, {req1_ready, req0_ready}, exp_id);
      end
      if (k > 0) begin
        tests_run++;
        if (n - last_n != 3) begin
          tests_failed++;
          $display("FAIL contention_period%0d: got %0d cycles expected 3", k, n - last_n);
        end
      end
      last_n = n;
      model_last = exp_id;
      @(negedge clock); @(negedge clock); n += 2;
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_id, (exp_id ? 32'd1 : 32'd6)}) begin
        tests_failed++;
        $display("FAIL contention_rsp%0d: got valid=%b id=%b res=%0d expected 1 %0d %0d",
                 k, rsp_valid, rsp_id, rsp_result, exp_id, exp_id ? 1 : 6);
      end
      @(negedge clock); n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    req1_control = 4'b0110; req1_operand_A = 32'd4; req1_operand_B = 32'd4;
    req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_accept: got rdy1/rdy0=%b expected 10", {req1_ready, req0_ready});
    end
    @(negedge clock);
    req1_valid = 1'b0;
    req0_control = 4'b0010; req0_operand_A = 32'd1; req0_operand_B = 32'd1; req0_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_zero, req0_ready, busy, rsp_result} !== {5'b11101, 32'd0}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid=%b id=%b zero=%b rdy0=%b busy=%b res=%h expected 1 1 1 0 1 0",
                 i, rsp_valid, rsp_id, rsp_zero, req0_ready, busy, rsp_result);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({rsp_valid, busy, req0_ready, rsp_zero, rsp_result} !== {4'b0011, 32'd0}) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b busy=%b rdy0=%b zero=%b res=%h expected 0 0 1 1 0",
               rsp_valid, busy, req0_ready, rsp_zero, rsp_result);
    end
    @(negedge clock);
    req0_valid = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd2}) begin
      tests_failed++;
      $display("FAIL bp_next: got valid=%b id=%b res=%0d expected 1 0 2", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clock);
    model_last = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    // Leave last grant on requester 0 so a surviving grant state would favour requester 1.
    req0_control = 4'b0001; req0_operand_A = 32'd2; req0_operand_B = 32'd4;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1; reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests_run++;
      if ({rsp_valid, busy, req0_ready, req1_ready, alu_control, alu_operand_A, alu_operand_B, rsp_result} !== 100'd0) begin
        tests_failed++;
        $display("FAIL midreset%0d: got valid=%b busy=%b rdy=%b%b ctrl=%h A=%h B=%h res=%h expected all 0",
                 i, rsp_valid, busy, req0_ready, req1_ready, alu_control, alu_operand_A, alu_operand_B, rsp_result);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL midreset_grant: got rdy1/rdy0=%b expected 01", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_passthrough();
    logic        ids [2];
    logic [3:0]  ctl [2];
    logic [31:0] exp_res [2];
    logic        exp_z [2];
    ids = '{1'b1, 1'b0}; ctl = '{4'b1100, 4'b0000};
    exp_res = '{32'hFFFF_FFF9, 32'h0}; exp_z = '{1'b0, 1'b1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (ids[i]) begin
        req1_control = ctl[i]; req1_operand_A = 32'd2; req1_operand_B = 32'd4; req1_valid = 1'b1;
      end else begin
        req0_control = ctl[i]; req0_operand_A = 32'd2; req0_operand_B = 32'd4; req0_valid = 1'b1;
      end
      @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clock);
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, ids[i], exp_z[i], exp_res[i]}) begin
        tests_failed++;
        $display("FAIL passthru%0d: got valid=%b id=%b zero=%b res=%h expected 1 %b %b %h",
                 i, rsp_valid, rsp_id, rsp_zero, rsp_result, ids[i], exp_z[i], exp_res[i]);
      end
      @(negedge clock);
      model_last = ids[i];
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops [6];
    logic        outstanding;
    int          acc_n;
    logic        exp_id;
    logic [31:0] exp_res;
    logic [1:0]  ack_prev;
    logic [1:0]  exp_rdy;
    logic        exp_rsp;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    outstanding = 1'b0; acc_n = 0; ack_prev = 2'b00; exp_id = 1'b0; exp_res = 32'd0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      // A requester may only change its request once the previous one was taken.
      if (!req0_valid || ack_prev[0]) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_control = ops[$urandom_range(0, 5)];
        req0_operand_A = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        req0_operand_B = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      if (!req1_valid || ack_prev[1]) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_control = ops[$urandom_range(0, 5)];
        req1_operand_A = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        req1_operand_B = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = 2'b00;
      if (!outstanding) begin
        if (req0_valid && req1_valid) exp_rdy = model_last ? 2'b01 : 2'b10;
        else if (req0_valid)          exp_rdy = 2'b01;
        else if (req1_valid)          exp_rdy = 2'b10;
      end
      exp_rsp = outstanding && (n >= acc_n + 2);
      tests_run++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rand_ready@%0d: got rdy1/rdy0=%b expected %b", n, {req1_ready, req0_ready}, exp_rdy);
      end
      tests_run++;
      if ({rsp_valid, busy} !== {exp_rsp, outstanding}) begin
        tests_failed++;
        $display("FAIL rand_status@%0d: got rsp_valid=%b busy=%b expected %b %b", n, rsp_valid, busy, exp_rsp, outstanding);
      end
      if (exp_rsp) begin
        tests_run++;
        if ({rsp_id, rsp_zero, rsp_result} !== {exp_id, (exp_res == 32'd0), exp_res}) begin
          tests_failed++;
          $display("FAIL rand_rsp@%0d: got id=%b zero=%b res=%h expected %b %b %h",
                   n, rsp_id, rsp_zero, rsp_result, exp_id, exp_res == 32'd0, exp_res);
        end
        if (rsp_ready) outstanding = 1'b0;
      end
      ack_prev = exp_rdy;
      if (exp_rdy != 2'b00) begin
        outstanding = 1'b1;
        acc_n = n;
        exp_id = exp_rdy[1];
        exp_res = exp_id ? alu_f(req1_control, req1_operand_A, req1_operand_B)
                         : alu_f(req0_control, req0_operand_A, req0_operand_B);
        model_last = exp_id;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run = 0; tests_failed = 0; model_last = 1'b1;
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_control = 4'd0; req0_operand_A = 32'd0; req0_operand_B = 32'd0;
    req1_valid = 1'b0; req1_control = 4'd0; req1_operand_A = 32'd0; req1_operand_B = 32'd0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
